// File: rtl/ro_freq_counter.sv
// Gated ring-oscillator edge counter: enables the RO, resynchronises its output and counts
// rising edges over a programmable window. Define RO_CNT_SAT_EN for a saturating count (default wraps).
module ro_freq_counter #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             ro_in_i,
  output logic             ro_enable_o,
  output logic             busy_o,
  output logic             count_valid_o,
  input  logic             count_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q;
  logic               edge_det;

  // Synchroniser and edge detector run continuously; only COUNT consumes edge_det.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort_i)              state_d = S_IDLE;
        else if (timer_q == '0)   state_d = (win_q == '0) ? S_DONE : S_COUNT;
      end
      S_COUNT: begin
        if (abort_i)              state_d = S_IDLE;
        else if (timer_q == '0)   state_d = S_DONE;
      end
      S_DONE: begin
        if (count_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ro_enable_o   = (state_q == S_SETTLE) || (state_q == S_COUNT);
    busy_o        = (state_q != S_IDLE);
    count_valid_o = (state_q == S_DONE);
    count_o       = count_q;
    overflow_o    = ovf_q;
  end

  // Timer is a down-counter reloaded per phase; its value after the final COUNT cycle is unused.
  always_comb begin
    timer_d = timer_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          win_d   = window_i;
          timer_d = TMR_W'(SETTLE_CYCLES - 1);
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (!abort_i) begin
          if (timer_q == '0) timer_d = TMR_W'(win_q) - TMR_W'(1);
          else               timer_d = timer_q - TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (!abort_i) begin
          timer_d = timer_q - TMR_W'(1);
          if (edge_det) begin
            if (count_q == {CNT_W{1'b1}}) begin
              ovf_d = 1'b1;
`ifdef RO_CNT_SAT_EN
              count_d = count_q;
`else
              count_d = '0;
`endif
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: expectations queued at start, checked when count_valid shows.
// Expected counts come from counting rising transitions in the logged RO sample stream.
module tb_ro_freq_counter;
  localparam int CNT_W = 6;
  localparam int WIN_W = 8;
  localparam int S     = 4;
  localparam int SYNC  = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int NPAT  = 40000;

  logic             clk = 1'b0;
  logic             rst, start, abort, ro_in, ready;
  logic [WIN_W-1:0] win;
  logic             ro_en, busy, valid, ovf;
  logic [CNT_W-1:0] cnt;

  ro_freq_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYCLES(S), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .window_i(win),
    .ro_in_i(ro_in), .ro_enable_o(ro_en), .busy_o(busy), .count_valid_o(valid),
    .count_ready_i(ready), .count_o(cnt), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int p0; int w; } meas_t;
  meas_t sb[$];
  int  n_cmp = 0, n_err = 0, n_issued = 0, n_done = 0;
  int  en_lo = 1, en_hi = 0;
  bit  ro_pat [0:NPAT-1];
  int  ro_mode = 0;
  bit  rdy_rand = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rising transitions of the RO as sampled by clk, over the w samples that reach the
  // counter during the window (shifted by the synchroniser depth).
  function automatic int model_edges(input int p0, input int w);
    int n = 0;
    for (int j = p0 + S - SYNC + 1; j <= p0 + S + w - SYNC; j++)
      if (ro_pat[j] && !ro_pat[j-1]) n++;
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // RO stimulus: value driven in cycle c is the sample taken at posedge c+1.
  initial begin
    ro_in = 1'b0;
    forever begin
      bit nxt;
      tick();
      case (ro_mode)
        0:       nxt = (((cyc + 1) / 5) % 2) == 1;
        1:       nxt = ((cyc + 1) % 2) == 1;
        2:       nxt = ($urandom % 2) == 1;
        default: nxt = (($urandom % 4) == 0) ? ~ro_in : ro_in;
      endcase
      if (cyc + 1 < NPAT) ro_pat[cyc+1] = nxt;
      ro_in = nxt;
    end
  end

  initial begin
    ready = 1'b0;
    forever begin
      tick();
      if (rdy_rand) ready = ($urandom % 3) != 0;
    end
  end

  always @(negedge clk) chk("ro_enable", int'(ro_en), int'(cyc >= en_lo && cyc <= en_hi));

  bit in_done = 1'b0;
  int e_cnt, e_ovf;
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        if (!in_done) begin
          int n;
          n = model_edges(sb[0].p0, sb[0].w);
`ifdef RO_CNT_SAT_EN
          e_cnt = (n > CMAX) ? CMAX : n;
`else
          e_cnt = n % (CMAX + 1);
`endif
          e_ovf = (n > CMAX) ? 1 : 0;
          chk("latency", cyc, sb[0].p0 + S + sb[0].w);
          in_done = 1'b1;
        end
        chk("count", int'(cnt), e_cnt);
        chk("overflow", int'(ovf), e_ovf);
        chk("done_busy", int'(busy), 1);
        if (ready) begin
          void'(sb.pop_front());
          in_done = 1'b0;
          n_done++;
        end
      end
    end
  end

  // Start presented in the current cycle c is accepted at the next edge: SETTLE begins in c+1.
  task automatic measure(input int w, input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    win   = WIN_W'(w);
    en_lo = cyc + 1;
    en_hi = cyc + S + w;
    sb.push_back('{p0: cyc + 1, w: w});
    n_issued++;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_done == n_issued) return;
    end
    chk("wait_done_timeout", n_done, n_issued);
    sb.delete();
    in_done = 1'b0;
    n_done = n_issued;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ro_enable"}, int'(ro_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_count"}, int'(cnt), 0);
    chk({tag, "_overflow"}, int'(ovf), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; win = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) tick();

    // period-10 RO, window 100
    ro_mode = 0; ready = 1'b1;
    measure(100, 1'b0);
    wait_done(300);

    // zero window goes straight to DONE
    measure(0, 1'b0);
    wait_done(50);

    // consumer stalls 20 cycles in DONE while start pulses arrive
    ready = 1'b0; ro_mode = 3;
    measure(30, 1'b0);
    repeat (S + 30) tick();
    for (int i = 0; i < 20; i++) begin
      start = (i % 3) == 0;
      win = 8'd5;
      chk("stall_valid", int'(valid), 1);
      tick();
    end
    start = 1'b0;
    ready = 1'b1;
    wait_done(10);

    // max-rate RO around the count limit
    ro_mode = 1;
    measure(126, 1'b0); wait_done(300);
    measure(128, 1'b0); wait_done(300);
    measure(200, 1'b0); wait_done(300);

    // start and abort together in IDLE: start wins
    ro_mode = 2;
    measure(20, 1'b1);
    wait_done(100);

    // abort at the tenth COUNT cycle
    start = 1'b1; win = 8'd50;
    en_lo = cyc + 1; en_hi = cyc + S + 50;
    tick();
    start = 1'b0;
    p0 = cyc;
    repeat (S + 9) tick();
    abort = 1'b1;
    en_hi = cyc;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    repeat (10) tick();

    // reset in the middle of SETTLE
    ro_mode = 0;
    start = 1'b1; win = 8'd40;
    en_lo = cyc + 1; en_hi = cyc + S + 40;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    en_hi = cyc;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    repeat (6) tick();

    // start held high: second run accepted one cycle after the DONE handshake
    ro_mode = 0; ready = 1'b1;
    start = 1'b1; win = 8'd100;
    p0 = cyc + 1;
    p1 = p0 + S + 100 + 2;
    en_lo = p0; en_hi = p0 + S + 100 - 1;
    sb.push_back('{p0: p0, w: 100});
    sb.push_back('{p0: p1, w: 100});
    n_issued += 2;
    while (cyc < p1 - 1) tick();
    en_lo = p1; en_hi = p1 + S + 100 - 1;
    tick();
    start = 1'b0;
    wait_done(400);

    // randomized runs
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int w, r;
      r = $urandom % 8;
      if (r == 0)      w = 0;
      else if (r == 1) w = 1;
      else if (r == 2) w = 255;
      else             w = $urandom_range(160, 2);
      ro_mode = $urandom % 4;
      measure(w, 1'b0);
      wait_done(w + 200);
      repeat ($urandom % 3) tick();
    end

    rdy_rand = 1'b0;
    repeat (5) tick();
    chk("final_idle_busy", int'(busy), 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
